// File: rtl/booth_pkg.sv
// Shared encodings for the Booth multiplier control unit: register op codes,
// M/adder controls and FSM state names.
package booth_pkg;

    typedef enum logic [1:0] {
        REG_LOAD  = 2'b00,
        REG_RESET = 2'b01,
        REG_SHIFT = 2'b10,
        REG_HOLD  = 2'b11
    } reg_op_t;

    localparam logic M_LD = 1'b1;
    localparam logic M_HD = 1'b0;
    localparam logic ADD  = 1'b0;
    localparam logic SUB  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_SHIFT,
        S_DONE
    } state_t;

endpackage

// File: rtl/booth_iter_counter.sv
// Saturating iteration counter for the Booth sequencer; 'last' flags that the
// next increment completes the final iteration.
module booth_iter_counter #(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
    localparam logic [CW:0]   WIDTH_W = (CW + 1)'(WIDTH);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != WIDTH_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Extra bit so count+1 cannot wrap when count already sits at WIDTH.
    assign last  = (({1'b0, count_q} + {{CW{1'b0}}, 1'b1}) == WIDTH_W);
    assign count = count_q;

endmodule

// File: rtl/booth_control_n.sv
// Control FSM for an N-bit Booth shift-add/subtract multiplier: sequences the
// M/A/Q registers and the adder, with a busy/done handshake.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | waiting for start; all controls hold
//   S_LOAD  | load M and Q, clear A, clear the iteration counter
//   S_EVAL  | inspect {Q[0],Q[-1]}: shift directly on 00/11, else add/sub
//   S_SHIFT | arithmetic shift of A:Q after an add/sub
//   S_DONE  | one-cycle done pulse, then back to idle
module booth_control_n
    import booth_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    Q_in,
    output logic [1:0]    Q_sig,
    output logic [1:0]    A_sig,
    output logic          M_sig,
    output logic          adder_sig,
    output logic          busy,
    output logic          done_sig,
    output logic [CW-1:0] count
);

    state_t state_q;
    state_t state_d;
    logic   cnt_clear;
    logic   cnt_inc;
    logic   cnt_last;

    booth_iter_counter #(.WIDTH(WIDTH)) u_iter_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .count   (count),
        .last    (cnt_last)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Q_in is only looked at in S_EVAL so an unknown pair elsewhere cannot leak in.
    always_comb begin
        state_d   = state_q;
        Q_sig     = REG_HOLD;
        A_sig     = REG_HOLD;
        M_sig     = M_HD;
        adder_sig = ADD;
        busy      = 1'b0;
        done_sig  = 1'b0;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                Q_sig     = REG_LOAD;
                A_sig     = REG_RESET;
                M_sig     = M_LD;
                busy      = 1'b1;
                cnt_clear = 1'b1;
                state_d   = S_EVAL;
            end
            S_EVAL: begin
                busy = 1'b1;
                case (Q_in)
                    2'b00, 2'b11: begin
                        Q_sig   = REG_SHIFT;
                        A_sig   = REG_SHIFT;
                        cnt_inc = 1'b1;
                        state_d = cnt_last ? S_DONE : S_EVAL;
                    end
                    2'b01: begin
                        A_sig     = REG_LOAD;
                        adder_sig = ADD;
                        state_d   = S_SHIFT;
                    end
                    2'b10: begin
                        A_sig     = REG_LOAD;
                        adder_sig = SUB;
                        state_d   = S_SHIFT;
                    end
                    default: begin
                        state_d = S_EVAL;
                    end
                endcase
            end
            S_SHIFT: begin
                Q_sig   = REG_SHIFT;
                A_sig   = REG_SHIFT;
                busy    = 1'b1;
                cnt_inc = 1'b1;
                state_d = cnt_last ? S_DONE : S_EVAL;
            end
            S_DONE: begin
                busy     = 1'b1;
                done_sig = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_control_n.sv
// Self-checking bench for booth_control_n: per-cycle comparison against a
// behavioural op-sequence model, plus literal latency and reset checks.
module tb_booth_control_n;

    localparam int W   = 4;
    localparam int CW  = 3;
    localparam int W8  = 8;
    localparam int CW8 = 4;

    logic clock = 1'b0;
    always #20 clock = ~clock;

    logic           reset_n;
    logic           start;
    logic [1:0]     q_in;
    logic [1:0]     Q_sig, A_sig;
    logic           M_sig, adder_sig, busy, done_sig;
    logic [CW-1:0]  count;

    logic           start8;
    logic [1:0]     q_in8;
    logic [1:0]     Q_sig8, A_sig8;
    logic           M_sig8, adder_sig8, busy8, done_sig8;
    logic [CW8-1:0] count8;

    booth_control_n #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .Q_in      (q_in),
        .Q_sig     (Q_sig),
        .A_sig     (A_sig),
        .M_sig     (M_sig),
        .adder_sig (adder_sig),
        .busy      (busy),
        .done_sig  (done_sig),
        .count     (count)
    );

    booth_control_n #(.WIDTH(W8)) dut8 (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start8),
        .Q_in      (q_in8),
        .Q_sig     (Q_sig8),
        .A_sig     (A_sig8),
        .M_sig     (M_sig8),
        .adder_sig (adder_sig8),
        .busy      (busy8),
        .done_sig  (done_sig8),
        .count     (count8)
    );

    typedef struct packed {
        logic [1:0]    q;
        logic [1:0]    a;
        logic          m;
        logic          ad;
        logic          b;
        logic          d;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void chk(input string name, input int tag, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, tag, act, req);
        end
    endfunction

    function automatic exp_t mk(input logic [1:0] q, input logic [1:0] a, input logic m,
                                input logic ad, input logic b, input logic d, input int c);
        exp_t e;
        e.q   = q;
        e.a   = a;
        e.m   = m;
        e.ad  = ad;
        e.b   = b;
        e.d   = d;
        e.cnt = c[CW-1:0];
        return e;
    endfunction

    // Output fields packed as {Q,A,M,adder,busy,done,count}.
    always @(negedge clock) begin
        exp_t e;
        int   t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk("outs", t, {Q_sig, A_sig, M_sig, adder_sig, busy, done_sig, count}, e);
        end
    end

    task automatic idle4(input int n, input int cnt);
        for (int i = 0; i < n; i++) begin
            q_in = 2'($urandom_range(0, 3));
            exp_q.push_back(mk(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, cnt));
            tag_q.push_back(-1);
            @(posedge clock);
            #1;
        end
    endtask

    // Model: a run is LOAD, then per Booth pair either one shift cycle (00/11)
    // or an add/sub cycle plus a shift cycle, then DONE.
    task automatic run4(input logic [2*W-1:0] pairs, input int prev, input int abort_at, output int lat);
        exp_t       list[$];
        logic [1:0] qv[$];
        logic [1:0] p;
        list.push_back(mk(2'b00, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, prev));
        qv.push_back(2'($urandom_range(0, 3)));
        for (int i = 0; i < W; i++) begin
            p = pairs[2*i +: 2];
            if (p == 2'b00 || p == 2'b11) begin
                list.push_back(mk(2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, i));
                qv.push_back(p);
            end else begin
                list.push_back(mk(2'b11, 2'b00, 1'b0, (p == 2'b10), 1'b1, 1'b0, i));
                qv.push_back(p);
                list.push_back(mk(2'b10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, i));
                qv.push_back(2'($urandom_range(0, 3)));
            end
        end
        list.push_back(mk(2'b11, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, W));
        qv.push_back(2'($urandom_range(0, 3)));

        start = 1'b1;
        q_in  = 2'($urandom_range(0, 3));
        exp_q.push_back(mk(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, prev));
        tag_q.push_back(-2);
        @(posedge clock);
        #1;
        start = 1'b0;
        lat   = -1;
        for (int k = 0; k < list.size(); k++) begin
            q_in = qv[k];
            exp_q.push_back(list[k]);
            tag_q.push_back(k);
            @(negedge clock);
            #2;
            if (done_sig && lat < 0) lat = k;
            if (k == abort_at) return;
            @(posedge clock);
            #1;
        end
    endtask

    function automatic int exp_lat(input logic [2*W-1:0] pairs);
        int n = 1 + W;
        for (int i = 0; i < W; i++) begin
            if (pairs[2*i +: 2] == 2'b01 || pairs[2*i +: 2] == 2'b10) n++;
        end
        return n;
    endfunction

    initial begin
        int              lat;
        int              first8;
        int              second8;
        logic [2*W-1:0]  pv;

        reset_n = 1'b0;
        start   = 1'b0;
        start8  = 1'b0;
        q_in    = 2'b00;
        q_in8   = 2'b00;

        #5;
        chk("rst_q",     0, Q_sig,     2'b11);
        chk("rst_a",     0, A_sig,     2'b11);
        chk("rst_m",     0, M_sig,     1'b0);
        chk("rst_adder", 0, adder_sig, 1'b0);
        chk("rst_busy",  0, busy,      1'b0);
        chk("rst_done",  0, done_sig,  1'b0);
        chk("rst_count", 0, count,     0);
        @(negedge clock);
        @(negedge clock);
        #5 reset_n = 1'b1;
        @(posedge clock);
        #1;
        idle4(10, 0);

        run4(8'h00, 0, -1, lat);
        chk("lat_all00", 0, lat, 5);
        idle4(1, W);
        run4(8'b01010101, W, -1, lat);
        chk("lat_all01", 0, lat, 9);
        idle4(2, W);
        run4(8'b10101010, W, -1, lat);
        chk("lat_all10", 0, lat, 9);
        idle4(1, W);
        run4(8'b11_01_00_10, W, -1, lat);
        chk("lat_mixed", 0, lat, 7);

        for (int r = 0; r < 20; r++) begin
            idle4($urandom_range(0, 3), W);
            pv = 8'($urandom);
            run4(pv, W, -1, lat);
            chk("lat_rand", r, lat, exp_lat(pv));
        end

        idle4(1, W);
        pv = {4'($urandom), 2'b01, 2'b00};
        run4(pv, W, 3, lat);
        chk("mid_count", 0, count, 1);
        chk("mid_busy",  0, busy,  1'b1);
        #5 reset_n = 1'b0;
        #1;
        chk("arst_q",     0, Q_sig,     2'b11);
        chk("arst_a",     0, A_sig,     2'b11);
        chk("arst_m",     0, M_sig,     1'b0);
        chk("arst_adder", 0, adder_sig, 1'b0);
        chk("arst_busy",  0, busy,      1'b0);
        chk("arst_count", 0, count,     0);
        #5 reset_n = 1'b1;
        @(posedge clock);
        #1;
        idle4(2, 0);
        pv = 8'($urandom);
        run4(pv, 0, -1, lat);
        chk("lat_after_rst", 0, lat, exp_lat(pv));
        idle4(2, W);

        first8  = -1;
        second8 = -1;
        start8  = 1'b1;
        q_in8   = 2'b00;
        @(posedge clock);
        for (int k = 0; k <= 21; k++) begin
            @(negedge clock);
            if (done_sig8) begin
                if (first8 < 0) begin
                    first8 = k;
                    chk("w8_done_count", k, count8, W8);
                end else if (second8 < 0) begin
                    second8 = k;
                end
            end
            if (k == 10) chk("w8_idle_busy", k, busy8, 1'b0);
            if (k == 11) chk("w8_reload_q", k, Q_sig8, 2'b00);
            @(posedge clock);
        end
        start8 = 1'b0;
        chk("w8_first_done",  0, first8,  9);
        chk("w8_second_done", 0, second8, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
